lifo_access_arbiter: RTL and testbench
======================================

Name: lifo_access_arbiter

Overview:
- Shares one single-port LIFO stack datapath between two requesters, A and B.
- Each requester issues push/pop transactions over a req/ack handshake. The arbiter grants round-robin and sequences the stack's two-phase command timing.
- Tracks occupancy, rejects illegal operations (push when full, pop when empty) without touching the stack, and returns pop data per requester.
- Sits between client logic and the stack memory block at top level.

Parameters:
- DW, 8, data width of stack entries and requester data.
- DEPTH, 256, stack entries; count width is clog2(DEPTH+1).
- CMD_CYCLES, 2, cycles stk_push/stk_pop must be held per operation (stack step phases).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_a, req_b  in  1  request level, held until ack.
- op_a, op_b  in  1  0=push, 1=pop.
- wdata_a, wdata_b  in  DW  push data.
- ack_a, ack_b  out  1  one-cycle completion pulse.
- err_a, err_b  out  1  valid with ack: 1 = rejected (overflow/underflow).
- rdata_a, rdata_b  out  DW  pop result, valid with ack, held until the next successful pop by the same requester.
- stk_push, stk_pop  out  1  stack command strobes.
- stk_wdata  out  DW  stack write data.
- stk_rdata  in  DW  stack read data, valid the cycle after the last pop command cycle.
- count  out  clog2(DEPTH+1)  current occupancy.
- full, empty  out  1  count==DEPTH, count==0.

Behaviour:
- Reset (rst_n low at a clock edge), regardless of state:
  - state=IDLE, rr pointer favours A.
  - count=0, empty=1, full=0.
  - All ack/err/stk_* outputs 0; rdata_a/b=0.
  - Mid-operation reset aborts the transaction with no ack; the stack datapath is reset in the same cycle.
- FSM states IDLE, EXEC, WAIT, ACK. All outputs registered.
- IDLE:
  - If any req is high, pick the winner: the sole requester, or if both, the one not granted last.
  - Latch winner id, op and wdata; update the rr pointer (on error grants too).
  - Illegal op (push with full, or pop with empty): go to ACK with err.
  - Otherwise go to EXEC with cycle counter=0.
- EXEC:
  - stk_push=~op, stk_pop=op, stk_wdata=latched data, held constant for exactly CMD_CYCLES cycles.
  - On the last cycle, count +1 (push) or -1 (pop). Then go to WAIT.
- WAIT:
  - Strobes 0 for one cycle.
  - For a pop, stk_rdata is captured at the end of WAIT into the winner's rdata register. Then go to ACK.
- ACK:
  - Winner's ack=1 for exactly one cycle; err=1 only for rejected ops. Then go to IDLE.
- Latency from grant edge: successful op acks CMD_CYCLES+2 cycles later (4 by default); rejected op acks 1 cycle later.
- Requester handshake:
  - The requester drops req on the edge where it samples ack; req high in the following cycle is a new request.
  - The op/wdata of a non-granted requester are ignored until its grant.
- count never wraps: it is bounded 0..DEPTH by the reject rule. A push at count=DEPTH-1 succeeds and sets full.
- Only one transaction is in flight. The stack never sees push and pop together, and the strobes are low outside EXEC.
- The losing requester waits at most one full transaction; there is no starvation.

Decomposition:
- Package lifo_arb_pkg holds:
  - state enum (IDLE, EXEC, WAIT, ACK);
  - OP_PUSH=0, OP_POP=1;
  - requester id constants REQ_A=0, REQ_B=1.
- Sub-module rr_arb2 is the 2-way round-robin picker: inputs req[1:0], update enable; outputs grant id and valid; contains the pointer register.

Test Plan:
- Reset, then A pushes 0x5A -> stk_push high 2 cycles with stk_wdata=0x5A; ack_a 4 cycles after grant, err_a=0, count=1, empty=0.
- A pushes 0x11, 0x22, then B pops twice -> rdata_b=0x22 at first ack_b, 0x11 at second; count back to 0, empty=1.
- Pop with count=0 (A) -> ack_a 1 cycle after grant with err_a=1, no stk_pop pulse, count stays 0.
- DEPTH=4: five pushes by B -> first four succeed, full=1 after the fourth; fifth returns err_b=1, count=4.
- req_a and req_b held high continuously with pushes -> grants alternate A,B,A,B; first grant is A after reset.
- Assert rst_n=0 during EXEC of a push -> next cycle state IDLE, strobes 0, count=0, no ack; a following request completes normally.

Source files
------------

// File: rtl/lifo_arb_pkg.sv
// Shared types and constants for the two-requester LIFO access arbiter.
package lifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; a tie goes to the requester not granted last.
module rr_arb2
  import lifo_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt_id,
  output logic       gnt_vld
);

  logic last_q, last_d;

  always_comb begin
    gnt_vld = |req;
    gnt_id  = (req == 2'b11) ? ~last_q : req[REQ_B];
    last_d  = upd ? gnt_id : last_q;
  end

  // Reset value marks B as last granted so A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= REQ_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/lifo_access_arbiter.sv
// Shares one single-port LIFO stack between requesters A and B, sequencing
// the stack's multi-cycle command strobes and rejecting over/underflow.
//
// state | meaning
// IDLE  | waiting for a request; grant, latch op/data, check legality
// EXEC  | stack strobe held for CMD_CYCLES cycles; count updated on the last
// WAIT  | strobes low; pop data captured from the stack at the end
// ACK   | completion pulse (with err for rejects) driven to the winner
module lifo_access_arbiter
  import lifo_arb_pkg::*;
#(
  parameter  int DW         = 8,
  parameter  int DEPTH      = 256,
  parameter  int CMD_CYCLES = 2,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          op_a,
  input  logic          op_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic          err_a,
  output logic          err_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_wdata,
  input  logic [DW-1:0] stk_rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int YW = (CMD_CYCLES > 1) ? $clog2(CMD_CYCLES) : 1;

  state_t        state_q, state_d;
  logic          id_q, id_d, op_q, op_d, rej_q, rej_d;
  logic [DW-1:0] data_q, data_d;
  logic [YW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic [1:0]    ack_q, ack_d, err_q, err_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic          push_q, push_d, pop_q, pop_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          gnt_id, gnt_vld, gnt_upd, gnt_op, illegal;
  logic [DW-1:0] gnt_data;

  // A requester still sees its ack on the edge it drops req, so mask it there.
  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req_b & ~ack_q[REQ_B], req_a & ~ack_q[REQ_A]}),
    .upd     (gnt_upd),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    op_d      = op_q;
    rej_d     = rej_q;
    data_d    = data_q;
    cyc_d     = cyc_q;
    count_d   = count_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    wdata_d   = wdata_q;
    gnt_upd   = 1'b0;
    gnt_op    = (gnt_id == REQ_B) ? op_b : op_a;
    gnt_data  = (gnt_id == REQ_B) ? wdata_b : wdata_a;
    illegal   = ((gnt_op == OP_PUSH) && full_q) || ((gnt_op == OP_POP) && empty_q);

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          gnt_upd = 1'b1;
          id_d    = gnt_id;
          op_d    = gnt_op;
          data_d  = gnt_data;
          rej_d   = illegal;
          cyc_d   = '0;
          if (illegal) begin
            state_d = ACK;
          end else begin
            state_d = EXEC;
            push_d  = (gnt_op == OP_PUSH);
            pop_d   = (gnt_op == OP_POP);
            wdata_d = gnt_data;
          end
        end
      end
      EXEC: begin
        if (cyc_q == YW'(CMD_CYCLES - 1)) begin
          state_d = WAIT;
          count_d = (op_q == OP_POP) ? count_q - CW'(1) : count_q + CW'(1);
        end else begin
          cyc_d  = cyc_q + YW'(1);
          push_d = (op_q == OP_PUSH);
          pop_d  = (op_q == OP_POP);
        end
      end
      WAIT: begin
        state_d = ACK;
        if (op_q == OP_POP) begin
          if (id_q == REQ_B) rdata_b_d = stk_rdata;
          else               rdata_a_d = stk_rdata;
        end
      end
      ACK: begin
        state_d     = IDLE;
        ack_d[id_q] = 1'b1;
        err_d[id_q] = rej_q;
      end
      default: state_d = IDLE;
    endcase

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= REQ_A;
      op_q      <= OP_PUSH;
      rej_q     <= 1'b0;
      data_q    <= '0;
      cyc_q     <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      op_q      <= op_d;
      rej_q     <= rej_d;
      data_q    <= data_d;
      cyc_q     <= cyc_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      push_q    <= push_d;
      pop_q     <= pop_d;
      wdata_q   <= wdata_d;
    end
  end

  assign ack_a     = ack_q[REQ_A];
  assign ack_b     = ack_q[REQ_B];
  assign err_a     = err_q[REQ_A];
  assign err_b     = err_q[REQ_B];
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_wdata = wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_lifo_access_arbiter.sv
// Bench for lifo_access_arbiter: directed and random transactions checked
// against a queue-based stack model and a small stack-memory emulation.
module tb_lifo_access_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CMDC  = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0, op_a = 1'b0, op_b = 1'b0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          ack_a, ack_b, err_a, err_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_wdata;
  logic [DW-1:0] stk_rdata = '0;
  logic [CW-1:0] count;
  logic          full, empty;

  always #5 clk = ~clk;

  lifo_access_arbiter #(.DW(DW), .DEPTH(DEPTH), .CMD_CYCLES(CMDC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata),
    .count(count), .full(full), .empty(empty)
  );

  // Stack memory: commits on the last strobe cycle, pop data valid the cycle after.
  logic [DW-1:0] mem [8];
  logic [2:0]    sp = '0;
  int            pcnt = 0, qcnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0; pcnt <= 0; qcnt <= 0;
    end else begin
      if (stk_push) begin
        pcnt <= pcnt + 1;
        if (pcnt == CMDC - 1) begin mem[sp] <= stk_wdata; sp <= sp + 3'd1; end
      end else pcnt <= 0;
      if (stk_pop) begin
        qcnt <= qcnt + 1;
        if (qcnt == CMDC - 1) begin stk_rdata <= mem[sp - 3'd1]; sp <= sp - 3'd1; end
      end else qcnt <= 0;
    end
  end

  int            push_tot = 0, pop_tot = 0;
  logic          both_seen = 1'b0, wbad = 1'b0, prev_push = 1'b0;
  logic [DW-1:0] prev_w = '0, last_pw = '0;
  always @(posedge clk) begin
    if (stk_push) push_tot <= push_tot + 1;
    if (stk_pop) pop_tot <= pop_tot + 1;
    if (stk_push && stk_pop) both_seen <= 1'b1;
    if (stk_push) last_pw <= stk_wdata;
    if (stk_push && prev_push && stk_wdata != prev_w) wbad <= 1'b1;
    prev_push <= stk_push;
    prev_w    <= stk_wdata;
  end

  int            checks = 0, errors = 0;
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] mdl_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("rdata_a", rdata_a, mdl_rd[0]);
    chk("rdata_b", rdata_b, mdl_rd[1]);
    chk("count", count, mdl_q.size());
    chk("full", full, mdl_q.size() == DEPTH);
    chk("empty", empty, mdl_q.size() == 0);
  endtask

  task automatic do_op(input logic id, input logic op, input logic [DW-1:0] d);
    int n, p0, q0;
    logic legal;
    legal = (op == 1'b0) ? (mdl_q.size() < DEPTH) : (mdl_q.size() > 0);
    @(posedge clk); #1;
    p0 = push_tot; q0 = pop_tot;
    if (id) begin req_b = 1'b1; op_b = op; wdata_b = d; end
    else    begin req_a = 1'b1; op_a = op; wdata_a = d; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(id ? ack_b : ack_a) && n < 20);
    chk("ack_latency", n, legal ? 6 : 3);
    chk("err", id ? err_b : err_a, !legal);
    chk("other_ack", id ? ack_a : ack_b, 0);
    if (legal) begin
      if (op == 1'b0) mdl_q.push_back(d);
      else            mdl_rd[id] = mdl_q.pop_back();
    end
    chk_state();
    chk("push_cycles", push_tot - p0, (legal && !op) ? CMDC : 0);
    chk("pop_cycles", pop_tot - q0, (legal && op) ? CMDC : 0);
    if (legal && !op) chk("stk_wdata", last_pw, d);
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mdl_q.delete();
    mdl_rd[0] = '0; mdl_rd[1] = '0;
  endtask

  initial begin
    int   n;
    logic exp_id, any_ack;
    mdl_rd[0] = '0; mdl_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_acks", {ack_b, ack_a, err_b, err_a}, 0);
    chk("rst_strobes", {stk_push, stk_pop}, 0);
    chk("rst_rdata", {rdata_b, rdata_a}, 0);

    do_op(1'b0, 1'b0, 8'h5A);
    do_op(1'b0, 1'b0, 8'h11);
    do_op(1'b0, 1'b0, 8'h22);
    do_op(1'b1, 1'b1, 8'h00);
    chk("lifo_first_pop", rdata_b, 8'h22);
    do_op(1'b1, 1'b1, 8'h00);
    chk("lifo_second_pop", rdata_b, 8'h11);
    do_op(1'b0, 1'b1, 8'h00);
    chk("lifo_third_pop", rdata_a, 8'h5A);
    do_op(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 8'(8'hC0 + i));
    chk("full_after_overflow", {full, count}, {1'b1, CW'(DEPTH)});

    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Both requesters held high: grants must alternate starting with A.
    do_reset();
    @(posedge clk); #1;
    req_a = 1'b1; req_b = 1'b1; op_a = 1'b0; op_b = 1'b0;
    wdata_a = 8'($urandom); wdata_b = 8'($urandom);
    exp_id = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(ack_a || ack_b) && n < 20);
      chk("alt_ack", {ack_b, ack_a}, exp_id ? 2 : 1);
      chk("alt_latency", n, (k == 0) ? 6 : 5);
      mdl_q.push_back(exp_id ? wdata_b : wdata_a);
      chk("alt_count", count, mdl_q.size());
      @(posedge clk); #1;
      if (!exp_id) begin wdata_a = 8'($urandom); if (k == 2) req_a = 1'b0; end
      else begin wdata_b = 8'($urandom); if (k == 3) req_b = 1'b0; end
      exp_id = ~exp_id;
    end
    for (int i = 0; i < 5; i++) do_op(1'($urandom_range(0, 1)), 1'b1, 8'h00);

    // Reset during EXEC of a push aborts with no ack.
    do_op(1'b1, 1'b0, 8'h3C);
    @(posedge clk); #1;
    req_a = 1'b1; op_a = 1'b0; wdata_a = 8'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!stk_push && n < 20);
    chk("exec_reached", stk_push, 1);
    rst_n = 1'b0; req_a = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {stk_push, stk_pop}, 0);
    chk("abort_count", count, 0);
    chk("abort_empty", empty, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    mdl_q.delete();
    mdl_rd[0] = '0; mdl_rd[1] = '0;
    any_ack = 1'b0;
    repeat (6) begin @(negedge clk); any_ack = any_ack | ack_a | ack_b; end
    chk("abort_no_ack", any_ack, 0);
    do_op(1'b1, 1'b0, 8'h77);
    do_op(1'b0, 1'b1, 8'h00);
    chk("post_abort_pop", rdata_a, 8'h77);

    chk("never_both_strobes", both_seen, 0);
    chk("wdata_stable", wbad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
